// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller: request opcodes and FSM states.
// Imported by cache_ctrl and its testbench.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    OP_GET = 2'd0,
    OP_PUT = 2'd1,
    OP_DEL = 2'd2,
    OP_RSV = 2'd3
  } ctrl_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    UPDATE  = 2'd2,
    RESPOND = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/cache_entry_array.sv
// Key/value/valid storage: one indexed async read port, one write port
// (sets valid), one per-entry valid clear. Ports: i_rd_*, o_rd_*, i_we/i_wr_*, i_clr*.
module cache_entry_array #(
  parameter int KW = 64,
  parameter int VW = 128,
  parameter int N  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(N)-1:0] i_rd_idx,
  output logic [KW-1:0]        o_rd_key,
  output logic [VW-1:0]        o_rd_value,
  output logic                 o_rd_valid,
  input  logic                 i_we,
  input  logic [$clog2(N)-1:0] i_wr_idx,
  input  logic [KW-1:0]        i_wr_key,
  input  logic [VW-1:0]        i_wr_value,
  input  logic                 i_clr,
  input  logic [$clog2(N)-1:0] i_clr_idx
);

  logic [KW-1:0] r_key   [N];
  logic [VW-1:0] r_value [N];
  logic [N-1:0]  r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_we)  r_valid[i_wr_idx]  <= 1'b1;
      if (i_clr) r_valid[i_clr_idx] <= 1'b0;
    end
  end

  // Payload needs no reset: an entry is meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_key[i_wr_idx]   <= i_wr_key;
      r_value[i_wr_idx] <= i_wr_value;
    end
  end

  assign o_rd_key   = r_key[i_rd_idx];
  assign o_rd_value = r_value[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Key/value cache controller: GET/PUT/DEL via valid/ready request and
// response handshakes, linear scan one entry per cycle.
// Ports: clk, rst, req_*, resp_*, occupancy;
// stat_hits/stat_misses only when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import ctrl_types_pkg::*;
#(
  parameter int ARCHITECTURE = 64,
  parameter int NUM_ENTRIES  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [ARCHITECTURE-1:0]       req_key,
  input  logic [2*ARCHITECTURE-1:0]     req_value,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_hit,
  output logic                          resp_error,
  output logic [2*ARCHITECTURE-1:0]     resp_value,
  output logic [$clog2(NUM_ENTRIES):0]  occupancy
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
`endif
);

  localparam int KW = ARCHITECTURE;
  localparam int VW = 2 * ARCHITECTURE;
  localparam int IW = $clog2(NUM_ENTRIES);

  ctrl_state_e   r_state, w_next;
  ctrl_op_e      r_op;
  logic [KW-1:0] r_key;
  logic [VW-1:0] r_wdata;
  logic [VW-1:0] r_value;
  logic [IW-1:0] r_idx, r_match_idx, r_free_idx;
  logic          r_free_found, r_hit, r_err;
  logic [IW:0]   r_occ;

  logic [KW-1:0] w_rd_key;
  logic [VW-1:0] w_rd_value;
  logic          w_rd_valid, w_match, w_last, w_accept;
  logic          w_we, w_clr;
  logic [IW-1:0] w_widx;

  cache_entry_array #(.KW(KW), .VW(VW), .N(NUM_ENTRIES)) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (r_idx),
    .o_rd_key   (w_rd_key),
    .o_rd_value (w_rd_value),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_we),
    .i_wr_idx   (w_widx),
    .i_wr_key   (r_key),
    .i_wr_value (r_wdata),
    .i_clr      (w_clr),
    .i_clr_idx  (r_match_idx)
  );

  assign w_match  = w_rd_valid && (w_rd_key == r_key);
  assign w_last   = (r_idx == IW'(NUM_ENTRIES - 1));
  assign w_accept = req_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_clr  = 1'b0;
    w_widx = r_match_idx;
    unique case (r_state)
      IDLE: begin
        if (req_valid)
          w_next = (req_op == OP_RSV) ? RESPOND : LOOKUP;
      end
      LOOKUP: begin
        if (w_match || w_last)
          w_next = (r_op == OP_GET) ? RESPOND : UPDATE;
      end
      UPDATE: begin
        w_next = RESPOND;
        if (r_op == OP_PUT) begin
          if (r_hit) begin
            w_we = 1'b1;
          end else if (r_free_found) begin
            w_we   = 1'b1;
            w_widx = r_free_idx;
          end
        end else if (r_op == OP_DEL) begin
          w_clr = r_hit;
        end
      end
      RESPOND: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= OP_GET;
      r_key        <= '0;
      r_wdata      <= '0;
      r_value      <= '0;
      r_idx        <= '0;
      r_match_idx  <= '0;
      r_free_idx   <= '0;
      r_free_found <= 1'b0;
      r_hit        <= 1'b0;
      r_err        <= 1'b0;
      r_occ        <= '0;
    end else if (w_accept) begin
      r_op         <= ctrl_op_e'(req_op);
      r_key        <= req_key;
      r_wdata      <= req_value;
      r_value      <= '0;
      r_idx        <= '0;
      r_free_found <= 1'b0;
      r_free_idx   <= '0;
      r_hit        <= 1'b0;
      r_err        <= (req_op == OP_RSV);
    end else if (r_state == LOOKUP) begin
      // Only the first free slot is kept, so PUT fills lowest index.
      if (!w_rd_valid && !r_free_found) begin
        r_free_found <= 1'b1;
        r_free_idx   <= r_idx;
      end
      if (w_match) begin
        r_hit       <= 1'b1;
        r_match_idx <= r_idx;
        if (r_op == OP_GET) r_value <= w_rd_value;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end else if (r_state == UPDATE) begin
      if (r_op == OP_PUT && !r_hit && !r_free_found)
        r_err <= 1'b1;
      if (w_we && !r_hit) r_occ <= r_occ + (IW+1)'(1);
      if (w_clr)          r_occ <= r_occ - (IW+1)'(1);
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESPOND);
  assign resp_hit   = resp_valid && r_hit;
  assign resp_error = resp_valid && r_err;
  assign resp_value = resp_valid ? r_value : '0;
  assign occupancy  = r_occ;

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] r_hits, r_misses;
  logic        w_get_done;

  assign w_get_done = resp_valid && resp_ready && (r_op == OP_GET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_get_done) begin
      if (r_hit && r_hits != '1)      r_hits   <= r_hits + 32'd1;
      if (!r_hit && r_misses != '1)   r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl (ARCHITECTURE=64, NUM_ENTRIES=8).
// Stats checks compile in only when CACHE_CTRL_STATS_EN is defined.
module tb_cache_ctrl;
  import ctrl_types_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [63:0]  req_key = '0;
  logic [127:0] req_value = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_hit;
  logic         resp_error;
  logic [127:0] resp_value;
  logic [3:0]   occupancy;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  int ntests = 0;
  int nfail  = 0;
  int lat;

  cache_ctrl #(.ARCHITECTURE(64), .NUM_ENTRIES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_value  (req_value),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_error (resp_error),
    .resp_value (resp_value),
    .occupancy  (occupancy)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request; return with lat = edges after the accept edge
  // until resp_valid is seen (0 = up in the cycle right after accept).
  task automatic txn(input logic [1:0] op, input logic [63:0] key,
                     input logic [127:0] val);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_value = val;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int elat,
                             input logic ehit, input logic eerr,
                             input logic [127:0] eval, input int eocc);
    chk({tag, "_lat"}, 128'(lat), 128'(elat));
    chk({tag, "_hit"}, 128'(resp_hit), 128'(ehit));
    chk({tag, "_err"}, 128'(resp_error), 128'(eerr));
    chk({tag, "_val"}, resp_value, eval);
    chk({tag, "_occ"}, 128'(occupancy), 128'(eocc));
  endtask

  initial begin
    do_reset();
    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_rvalid", 128'(resp_valid), 128'(0));
    chk("rst_hit", 128'(resp_hit), 128'(0));
    chk("rst_err", 128'(resp_error), 128'(0));
    chk("rst_val", resp_value, 128'h0);
    chk("rst_occ", 128'(occupancy), 128'(0));

    // Miss on empty cache: full 8-entry scan.
    txn(OP_GET, 64'h11, '0);
    expect_resp("get_empty", 8, 0, 0, 128'h0, 0);
    ack();

    // PUT miss: scan + one UPDATE cycle, lands index 0.
    txn(OP_PUT, 64'h11, 128'hAB);
    expect_resp("put_11", 9, 0, 0, 128'h0, 1);
    ack();
    txn(OP_GET, 64'h11, '0);
    expect_resp("get_11", 1, 1, 0, 128'hAB, 1);
    ack();

    // Fill indices 1..7 with keys 0x20..0x26, values 0x1000..0x1006.
    for (int k = 0; k < 7; k++) begin
      txn(OP_PUT, 64'h20 + 64'(k), 128'h1000 + 128'(k));
      chk("fill_lat", 128'(lat), 128'(9));
      chk("fill_hit", 128'(resp_hit), 128'(0));
      chk("fill_occ", 128'(occupancy), 128'(k + 2));
      ack();
    end

    txn(OP_PUT, 64'h99, 128'h99);
    expect_resp("put_full", 9, 0, 1, 128'h0, 8);
    ack();

    // Overwrite in place at index 0.
    txn(OP_PUT, 64'h11, 128'hCD);
    expect_resp("put_ovw", 2, 1, 0, 128'h0, 8);
    ack();
    txn(OP_GET, 64'h11, '0);
    expect_resp("get_ovw", 1, 1, 0, 128'hCD, 8);
    ack();

    // Key 0x22 sits at index 3.
    txn(OP_DEL, 64'h22, '0);
    expect_resp("del_22", 5, 1, 0, 128'h0, 7);
    ack();
    txn(OP_PUT, 64'h77, 128'h7777);
    expect_resp("put_77", 9, 0, 0, 128'h0, 8);
    ack();
    txn(OP_GET, 64'h77, '0);
    expect_resp("get_77", 4, 1, 0, 128'h7777, 8);
    ack();

    txn(OP_DEL, 64'h55, '0);
    expect_resp("del_miss", 9, 0, 0, 128'h0, 8);
    ack();

    // Backpressure: fields must hold for 5 cycles.
    txn(OP_GET, 64'h23, '0);
    expect_resp("get_23", 5, 1, 0, 128'h1003, 8);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_vld", 128'(resp_valid), 128'(1));
      chk("hold_hit", 128'(resp_hit), 128'(1));
      chk("hold_val", resp_value, 128'h1003);
      chk("hold_rdy", 128'(req_ready), 128'(0));
    end
    ack();
    chk("post_ack_vld", 128'(resp_valid), 128'(0));
    chk("post_ack_rdy", 128'(req_ready), 128'(1));

    txn(OP_RSV, 64'h11, '0);
    expect_resp("op3", 0, 0, 1, 128'h0, 8);
    ack();

    // Reset while a PUT sits in UPDATE: nothing may be written.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_PUT;
    req_key   = 64'h42;
    req_value = 128'h4242;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("upd_no_resp", 128'(resp_valid), 128'(0));
    rst = 1'b1;
    #2;
    chk("mid_rst_occ", 128'(occupancy), 128'(0));
    chk("mid_rst_vld", 128'(resp_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rdy", 128'(req_ready), 128'(1));
    txn(OP_GET, 64'h42, '0);
    expect_resp("get_42", 8, 0, 0, 128'h0, 0);
    ack();

`ifdef CACHE_CTRL_STATS_EN
    do_reset();
    chk("stat_rst_h", 128'(stat_hits), 128'(0));
    chk("stat_rst_m", 128'(stat_misses), 128'(0));
    txn(OP_PUT, 64'h5, 128'h55);
    ack();
    txn(OP_GET, 64'h5, '0);
    ack();
    txn(OP_GET, 64'h5, '0);
    ack();
    txn(OP_GET, 64'h6, '0);
    ack();
    chk("stat_hits", 128'(stat_hits), 128'(2));
    chk("stat_misses", 128'(stat_misses), 128'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
